// File: rtl/timer_apb_slave_if.sv
// APB bus bundle between the system bus master and one timer register block.
interface timer_apb_slave_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_slave.sv
// APB responder and TDR/TCR/TSR register file for one 8-bit timer; feeds the
// counter core its control fields and latches its overflow/underflow events.
module timer_apb_slave #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    timer_apb_slave_if.slave    apb,
    output logic [7:0]          tdr,
    output logic                tcr_load,
    output logic                tcr_down,
    output logic                tcr_en,
    output logic [1:0]          tcr_cks,
    input  logic                ovf_set,
    input  logic                udf_set
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYCLES);
    localparam logic [7:0]        TCR_MASK  = 8'hB3;
    localparam logic [ADDR_W-1:0] ADDR_TDR  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TSR  = ADDR_W'(2);

    state_t     state, state_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic       done;

    logic [7:0] tdr_q;
    logic [7:0] tcr_q;
    logic [1:0] tsr_q, tsr_nxt;

    logic       addr_err;
    logic       wr_en;
    logic [7:0] rd_val;

    // wait_cnt is zero in SETUP, so SETUP and ACCESS share one countdown path.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (apb.psel && !apb.penable) state_nxt = SETUP;
            end
            SETUP, ACCESS: begin
                if (!apb.psel) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (!apb.penable) begin
                    state_nxt    = SETUP;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    done         = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        addr_err = (apb.paddr > ADDR_TSR);
        wr_en    = done && apb.pwrite && !addr_err;
        rd_val   = 8'h00;
        unique case (apb.paddr)
            ADDR_TDR: rd_val = tdr_q;
            ADDR_TCR: rd_val = tcr_q;
            ADDR_TSR: rd_val = {6'b0, tsr_q};
            default:  rd_val = 8'h00;
        endcase
    end

    // A software 0 clears a flag, but a same-cycle event from the core wins.
    always_comb begin
        tsr_nxt = tsr_q;
        if (wr_en && apb.paddr == ADDR_TSR) tsr_nxt = tsr_q & apb.pwdata[1:0];
        tsr_nxt = tsr_nxt | {udf_set, ovf_set};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        // NOTE: reset is sampled synchronously here; the register file is small enough to clear entirely.
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tdr_q    <= 8'h00;
            tcr_q    <= 8'h00;
            tsr_q    <= 2'b00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            tsr_q    <= tsr_nxt;
            if (wr_en && apb.paddr == ADDR_TDR) tdr_q <= apb.pwdata;
            if (wr_en && apb.paddr == ADDR_TCR) tcr_q <= apb.pwdata & TCR_MASK;
        end
    end

    assign apb.pready  = done;
    assign apb.pslverr = done && addr_err;
    assign apb.prdata  = (done && !addr_err) ? rd_val : 8'h00;

    assign tdr      = tdr_q;
    assign tcr_load = tcr_q[7];
    assign tcr_down = tcr_q[5];
    assign tcr_en   = tcr_q[4];
    assign tcr_cks  = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Bench for timer_apb_slave: one instance with no wait states and one with three,
// driven by directed and random APB traffic and compared to a register-level model.
module tb_timer_apb_slave;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    int         cur;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;

    timer_apb_slave_if #(.ADDR_W(8)) apb0 ();
    timer_apb_slave_if #(.ADDR_W(8)) apb3 ();

    assign apb0.psel    = psel && (cur == 0);
    assign apb3.psel    = psel && (cur == 1);
    assign apb0.penable = penable;
    assign apb3.penable = penable;
    assign apb0.pwrite  = pwrite;
    assign apb3.pwrite  = pwrite;
    assign apb0.paddr   = paddr;
    assign apb3.paddr   = paddr;
    assign apb0.pwdata  = pwdata;
    assign apb3.pwdata  = pwdata;

    logic [1:0][7:0] tdr_o;
    logic [1:0]      load_o, down_o, en_o;
    logic [1:0][1:0] cks_o;
    logic [1:0]      ovf, udf;

    timer_apb_slave #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .apb(apb0),
        .tdr(tdr_o[0]), .tcr_load(load_o[0]), .tcr_down(down_o[0]), .tcr_en(en_o[0]),
        .tcr_cks(cks_o[0]), .ovf_set(ovf[0]), .udf_set(udf[0])
    );

    timer_apb_slave #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset(preset), .apb(apb3),
        .tdr(tdr_o[1]), .tcr_load(load_o[1]), .tcr_down(down_o[1]), .tcr_en(en_o[1]),
        .tcr_cks(cks_o[1]), .ovf_set(ovf[1]), .udf_set(udf[1])
    );

    logic       b_pready, b_pslverr;
    logic [7:0] b_prdata;
    always_comb begin
        b_pready  = (cur == 0) ? apb0.pready  : apb3.pready;
        b_pslverr = (cur == 0) ? apb0.pslverr : apb3.pslverr;
        b_prdata  = (cur == 0) ? apb0.prdata  : apb3.prdata;
    end

    // Register-level model: what software should see in each register.
    int         wait_of [2] = '{0, 3};
    logic [7:0] m_tdr [2];
    logic [7:0] m_tcr [2];
    logic [1:0] m_tsr [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (unit %0d): got 0x%0h expected 0x%0h at %0t", tag, cur, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] addr);
        case (addr)
            8'd0:    return m_tdr[cur];
            8'd1:    return m_tcr[cur];
            8'd2:    return {6'b0, m_tsr[cur]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [7:0] data);
        case (addr)
            8'd0: m_tdr[cur] = data;
            8'd1: m_tcr[cur] = data & 8'hB3;
            8'd2: m_tsr[cur] = m_tsr[cur] & data[1:0];
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_tdr[u] = 8'h00;
            m_tcr[u] = 8'h00;
            m_tsr[u] = 2'b00;
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [7:0] t;
        t = m_tcr[cur];
        check({tag, "_tdr"}, tdr_o[cur], m_tdr[cur]);
        check({tag, "_tcr_out"}, {load_o[cur], down_o[cur], en_o[cur], cks_o[cur]},
              {t[7], t[5], t[4], t[1:0]});
    endtask

    // One complete transfer; ev pulses {udf,ovf} on the same edge that completes it.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [1:0] ev, output logic [7:0] rdata);
        int   lat;
        logic done;
        logic [7:0] exp_rd;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        lat = 1; done = 1'b0; rdata = 8'h00;
        @(negedge pclk);
        penable = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            lat++;
            if (b_pready) begin
                done   = 1'b1;
                exp_rd = model_read(addr);
                rdata  = b_prdata;
                check("latency", lat, 2 + wait_of[cur]);
                check("pslverr", b_pslverr, addr > 8'd2);
                if (!wr) check("prdata", b_prdata, exp_rd);
                ovf[cur] = ev[0];
                udf[cur] = ev[1];
                @(posedge pclk);
                #1;
                ovf[cur] = 1'b0;
                udf[cur] = 1'b0;
                if (wr) model_write(addr, wdata);
                m_tsr[cur] = m_tsr[cur] | ev;
                check_outputs("post_commit");
            end else begin
                check_outputs("pre_commit");
                @(negedge pclk);
            end
        end
        if (!done) check("pready_timeout", lat, 2 + wait_of[cur]);
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        #1;
        check("idle_pready", b_pready, 1'b0);
        check("idle_prdata", b_prdata, 8'h00);
    endtask

    task automatic pulse(input logic [1:0] ev);
        @(negedge pclk);
        ovf[cur] = ev[0];
        udf[cur] = ev[1];
        @(posedge pclk);
        #1;
        ovf[cur] = 1'b0;
        udf[cur] = 1'b0;
        m_tsr[cur] = m_tsr[cur] | ev;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        model_reset();
    endtask

    task automatic read_expect(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        logic [7:0] rd;
        xfer(1'b0, addr, 8'h00, 2'b00, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        cur = 0; preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf = '0; udf = '0;
        model_reset();

        do_reset();
        #1;
        check("reset_pready", b_pready, 1'b0);
        check_outputs("reset");
        for (int a = 0; a < 3; a++) read_expect(8'(a), 8'h00, "reset_read");
        idle();

        xfer(1'b1, 8'h00, 8'hA5, 2'b00, rd);
        xfer(1'b1, 8'h01, 8'hFF, 2'b00, rd);
        read_expect(8'h00, 8'hA5, "tdr_read");
        read_expect(8'h01, 8'hB3, "tcr_masked_read");
        idle();

        pulse(2'b10);
        read_expect(8'h02, 8'h02, "tsr_udf");
        xfer(1'b1, 8'h02, 8'h01, 2'b00, rd);
        read_expect(8'h02, 8'h00, "tsr_cleared");
        pulse(2'b01);
        xfer(1'b1, 8'h02, 8'h00, 2'b01, rd);
        read_expect(8'h02, 8'h01, "tsr_set_wins");
        idle();

        xfer(1'b1, 8'h05, 8'h3C, 2'b00, rd);
        read_expect(8'h05, 8'h00, "bad_addr_read");
        read_expect(8'h00, 8'hA5, "tdr_after_bad_write");
        idle();

        // Setup phase abandoned: no write may land.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        @(negedge pclk);
        psel = 1'b0;
        read_expect(8'h00, 8'hA5, "abort_setup");
        idle();

        cur = 1;
        xfer(1'b1, 8'h01, 8'h31, 2'b00, rd);
        idle();
        // Access phase abandoned mid-wait.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h22;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        read_expect(8'h00, 8'h00, "abort_access");

        // Reset lands in the middle of a TDR write.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h7F;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        model_reset();
        check("reset_mid_pready", b_pready, 1'b0);
        check_outputs("reset_mid");
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        read_expect(8'h00, 8'h00, "tdr_after_reset");
        idle();

        for (int u = 0; u < 2; u++) begin
            cur = u;
            for (int n = 0; n < 150; n++) begin
                logic [7:0] a;
                logic [1:0] ev;
                a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(3, 255)) : 8'($urandom_range(0, 2));
                ev = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                xfer(1'($urandom_range(0, 1)), a, 8'($urandom), ev, rd);
                case ($urandom_range(0, 3))
                    0: idle();
                    1: pulse(2'($urandom_range(1, 3)));
                    default: ;
                endcase
            end
            idle();
            read_expect(8'h02, {6'b0, m_tsr[u]}, "final_tsr");
            idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
